// File: rtl/gen_out_scl.sv
// gen_out_scl: output scaling stage behind the signal generator.
// Applies a per-channel gain and DC offset to the generator's signed
// sample stream, saturates to the DAC word width and forwards the result
// on an AXI4-Stream style master.  A mute (cfg_ena) and a saturation
// event counter are provided for the register block.
module gen_out_scl #(
    parameter int DWI = 14,  // input sample width (signed)
    parameter int DWM = 16,  // gain width (signed, unity = 2^(DWM-2))
    parameter int DWS = 14,  // offset width (signed)
    parameter int DWO = 14,  // output sample width (signed)
    parameter int CNW = 16   // saturation counter width
) (
    input  logic                  clk,
    input  logic                  rst,
    // input stream from the generator
    input  logic signed [DWI-1:0] sti_tdata,
    input  logic                  sti_tlast,
    input  logic                  sti_tvalid,
    output logic                  sti_tready,
    // output stream toward the DAC
    output logic signed [DWO-1:0] sto_tdata,
    output logic                  sto_tlast,
    output logic                  sto_tvalid,
    input  logic                  sto_tready,
    // configuration
    input  logic signed [DWM-1:0] cfg_mul,
    input  logic signed [DWS-1:0] cfg_sum,
    input  logic                  cfg_ena,
    input  logic                  cfg_clr,
    // status
    output logic        [CNW-1:0] sts_sat
);

    // Full product width, and the width of the shifted-plus-offset sum.
    // The shifted product fits in DWI+2 bits; one extra bit over the wider
    // of the two addends makes the addition overflow free.
    localparam int PW = DWI + DWM;
    localparam int SW = ((DWI + 2 > DWS) ? DWI + 2 : DWS) + 1;

    // Output clipping limits expressed at the sum width.
    localparam logic signed [SW-1:0] OMAX = SW'((1 << (DWO - 1)) - 1);
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

    // Global pipeline enable: the whole pipe moves unless the output is stalled.
    logic ce;
    logic xfer_in;
    logic xfer_out;

    assign ce         = ~sto_tvalid | sto_tready;
    assign sti_tready = ce & ~rst;
    assign xfer_in    = sti_tvalid & sti_tready;
    assign xfer_out   = sto_tvalid & sto_tready;

    // Stage 1 registers: exact product plus the config captured with the sample.
    logic                  s1_vld;
    logic signed [PW-1:0]  s1_p;
    logic signed [DWS-1:0] s1_sum;
    logic                  s1_ena;
    logic                  s1_last;

    // Stage 2 registers: gain-scaled sample with offset applied.
    logic                  s2_vld;
    logic signed [SW-1:0]  s2_s;
    logic                  s2_ena;
    logic                  s2_last;

    // Stage 3 saturation flag travels with the output word.
    logic                  s3_sat;

    // Combinational helpers between stages.
    logic signed [PW-1:0]  p_shr;
    logic signed [SW-1:0]  s2_next;
    logic signed [DWO-1:0] sat_data;
    logic                  sat_flag;

    // Arithmetic shift floors toward -inf; offset is sign-extended to the sum width.
    assign p_shr   = s1_p >>> (DWM - 2);
    assign s2_next = SW'(p_shr) + SW'(s1_sum);

    // S1: multiply the accepted sample by its gain and capture the config set.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_p    <= '0;
            s1_sum  <= '0;
            s1_ena  <= 1'b0;
            s1_last <= 1'b0;
        end else if (ce) begin
            s1_vld <= xfer_in;
            if (xfer_in) begin
                s1_p    <= PW'(sti_tdata) * PW'(cfg_mul);
                s1_sum  <= cfg_sum;
                s1_ena  <= cfg_ena;
                s1_last <= sti_tlast;
            end
        end
    end

    // S2: rescale the product and add the offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_s    <= '0;
            s2_ena  <= 1'b0;
            s2_last <= 1'b0;
        end else if (ce) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_s    <= s2_next;
                s2_ena  <= s1_ena;
                s2_last <= s1_last;
            end
        end
    end

    // Clip the sum to the DAC range, or force zero when the sample was muted.
    always_comb begin
        sat_flag = 1'b0;
        sat_data = DWO'(s2_s);
        if (!s2_ena) begin
            sat_data = '0;
        end else if (s2_s > OMAX) begin
            sat_data = DWO'(OMAX);
            sat_flag = 1'b1;
        end else if (s2_s < OMIN) begin
            sat_data = DWO'(OMIN);
            sat_flag = 1'b1;
        end
    end

    // S3: output register; holds while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            sto_tvalid <= 1'b0;
            sto_tdata  <= '0;
            sto_tlast  <= 1'b0;
            s3_sat     <= 1'b0;
        end else if (ce) begin
            sto_tvalid <= s2_vld;
            if (s2_vld) begin
                sto_tdata <= sat_data;
                sto_tlast <= s2_last;
                s3_sat    <= sat_flag;
            end
        end
    end

    // Count clipped output transfers; sticks at all ones and clear has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            sts_sat <= '0;
        end else if (cfg_clr) begin
            sts_sat <= '0;
        end else if (xfer_out && s3_sat && !(&sts_sat)) begin
            sts_sat <= sts_sat + 1'b1;
        end
    end

endmodule

// File: tb/tb_gen_out_scl.sv
// tb_gen_out_scl: directed self-checking bench for gen_out_scl.
// Inputs are driven 1 time unit after the rising edge, outputs are
// checked on the falling edge; a monitor records every output transfer.
module tb_gen_out_scl;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [13:0] sti_tdata;
    logic               sti_tlast;
    logic               sti_tvalid;
    logic               sti_tready;
    logic signed [13:0] sto_tdata;
    logic               sto_tlast;
    logic               sto_tvalid;
    logic               sto_tready;
    logic signed [15:0] cfg_mul;
    logic signed [13:0] cfg_sum;
    logic               cfg_ena;
    logic               cfg_clr;
    logic        [15:0] sts_sat;

    int tests = 0;
    int fails = 0;

    logic signed [13:0] out_q[$];
    logic               last_q[$];

    gen_out_scl dut (
        .clk        (clk),
        .rst        (rst),
        .sti_tdata  (sti_tdata),
        .sti_tlast  (sti_tlast),
        .sti_tvalid (sti_tvalid),
        .sti_tready (sti_tready),
        .sto_tdata  (sto_tdata),
        .sto_tlast  (sto_tlast),
        .sto_tvalid (sto_tvalid),
        .sto_tready (sto_tready),
        .cfg_mul    (cfg_mul),
        .cfg_sum    (cfg_sum),
        .cfg_ena    (cfg_ena),
        .cfg_clr    (cfg_clr),
        .sts_sat    (sts_sat)
    );

    always #5 clk = ~clk;

    // Record every output transfer that will happen at the next rising edge.
    always @(negedge clk) begin
        if (sto_tvalid && sto_tready && !rst) begin
            out_q.push_back(sto_tdata);
            last_q.push_back(sto_tlast);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic l);
        sti_tdata  = 14'(d);
        sti_tlast  = l;
        sti_tvalid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (sti_tready !== 1'b0) begin fails++; $display("[TB] FAIL reset_tready_low: got %b expected 0", sti_tready); end
        step();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (sto_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tvalid: got %b expected 0", sto_tvalid); end
        tests++;
        if (sto_tdata !== 14'sd0) begin fails++; $display("[TB] FAIL reset_tdata: got %0d expected 0", sto_tdata); end
        tests++;
        if (sto_tlast !== 1'b0) begin fails++; $display("[TB] FAIL reset_tlast: got %b expected 0", sto_tlast); end
        tests++;
        if (sts_sat !== 16'd0) begin fails++; $display("[TB] FAIL reset_sts_sat: got %0d expected 0", sts_sat); end
        tests++;
        if (sti_tready !== 1'b1) begin fails++; $display("[TB] FAIL reset_tready_high: got %b expected 1", sti_tready); end
    endtask

    task automatic test_passthrough();
        int   vals[4];
        logic exp_v;
        vals = '{100, -100, 8191, -8192};
        step();
        cfg_mul = 16'sd16384; cfg_sum = 14'sd0; cfg_ena = 1'b1; sto_tready = 1'b1;
        drive(vals[0], 1'b0);
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j < 4) drive(vals[j], 1'b0);
            else sti_tvalid = 1'b0;
            @(negedge clk);
            exp_v = (j >= 3 && j <= 6);
            tests++;
            if (sto_tvalid !== exp_v) begin fails++; $display("[TB] FAIL pass_valid_c%0d: got %b expected %b", j, sto_tvalid, exp_v); end
            if (exp_v) begin
                tests++;
                if (sto_tdata !== 14'(vals[j-3])) begin fails++; $display("[TB] FAIL pass_data_c%0d: got %0d expected %0d", j, sto_tdata, vals[j-3]); end
            end
        end
        tests++;
        if (sts_sat !== 16'd0) begin fails++; $display("[TB] FAIL pass_sts_sat: got %0d expected 0", sts_sat); end
    endtask

    task automatic test_gain_offset();
        step();
        out_q.delete(); last_q.delete();
        cfg_mul = 16'sd8192; cfg_sum = 14'sd10;
        drive(-101, 1'b0);
        step();
        drive(101, 1'b0);
        step();
        sti_tvalid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        tests++;
        if (out_q.size() != 2) begin
            fails++; $display("[TB] FAIL gain_count: got %0d expected 2", out_q.size());
        end else begin
            tests++;
            if (out_q[0] !== -14'sd41) begin fails++; $display("[TB] FAIL gain_neg_floor: got %0d expected -41", out_q[0]); end
            tests++;
            if (out_q[1] !== 14'sd60) begin fails++; $display("[TB] FAIL gain_pos: got %0d expected 60", out_q[1]); end
        end
        tests++;
        if (sts_sat !== 16'd0) begin fails++; $display("[TB] FAIL gain_sts_sat: got %0d expected 0", sts_sat); end
    endtask

    task automatic test_saturation();
        step();
        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
        out_q.delete(); last_q.delete();
        cfg_mul = 16'sd32767; cfg_sum = 14'sd0;
        drive(8000, 1'b0);
        step();
        drive(-8192, 1'b0);
        step();
        cfg_mul = 16'sd16384; cfg_sum = 14'sd100;
        drive(8191, 1'b0);
        step();
        sti_tvalid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        tests++;
        if (out_q.size() != 3) begin
            fails++; $display("[TB] FAIL sat_count: got %0d expected 3", out_q.size());
        end else begin
            tests++;
            if (out_q[0] !== 14'sd8191) begin fails++; $display("[TB] FAIL sat_pos: got %0d expected 8191", out_q[0]); end
            tests++;
            if (out_q[1] !== -14'sd8192) begin fails++; $display("[TB] FAIL sat_neg: got %0d expected -8192", out_q[1]); end
            tests++;
            if (out_q[2] !== 14'sd8191) begin fails++; $display("[TB] FAIL sat_offset: got %0d expected 8191", out_q[2]); end
        end
        tests++;
        if (sts_sat !== 16'd3) begin fails++; $display("[TB] FAIL sat_counter: got %0d expected 3", sts_sat); end
        step();
        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (sts_sat !== 16'd0) begin fails++; $display("[TB] FAIL sat_clear: got %0d expected 0", sts_sat); end
        // clip on the very cycle of a clear pulse: clear must win
        step();
        cfg_mul = 16'sd32767; cfg_sum = 14'sd0;
        drive(8000, 1'b0);
        step();
        sti_tvalid = 1'b0;
        step();
        step();
        cfg_clr = 1'b1;
        @(negedge clk);
        tests++;
        if (sto_tvalid !== 1'b1) begin fails++; $display("[TB] FAIL clr_win_valid: got %b expected 1", sto_tvalid); end
        step();
        cfg_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (sts_sat !== 16'd0) begin fails++; $display("[TB] FAIL clr_wins: got %0d expected 0", sts_sat); end
        tests++;
        if (out_q.size() != 4) begin fails++; $display("[TB] FAIL clr_win_xfer: got %0d expected 4", out_q.size()); end
        step();
        drive(-8192, 1'b0);
        step();
        sti_tvalid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        tests++;
        if (sts_sat !== 16'd1) begin fails++; $display("[TB] FAIL sat_recount: got %0d expected 1", sts_sat); end
    endtask

    task automatic test_mute();
        logic [15:0]        sat_before;
        logic signed [13:0] exp_d;
        step();
        out_q.delete(); last_q.delete();
        sat_before = sts_sat;
        cfg_mul = 16'sd16384; cfg_sum = 14'sd0; cfg_ena = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) cfg_ena = 1'b0;
            drive(i, 1'b0);
            step();
        end
        sti_tvalid = 1'b0;
        cfg_ena = 1'b1;
        repeat (6) step();
        @(negedge clk);
        tests++;
        if (out_q.size() != 10) begin
            fails++; $display("[TB] FAIL mute_count: got %0d expected 10", out_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                exp_d = (i < 5) ? 14'(i + 1) : 14'sd0;
                tests++;
                if (out_q[i] !== exp_d) begin fails++; $display("[TB] FAIL mute_data_%0d: got %0d expected %0d", i, out_q[i], exp_d); end
            end
        end
        tests++;
        if (sts_sat !== sat_before) begin fails++; $display("[TB] FAIL mute_sts_sat: got %0d expected %0d", sts_sat, sat_before); end
    endtask

    task automatic test_backpressure();
        int                 idx;
        logic               acc;
        logic               have_prev;
        logic signed [13:0] prev_d;
        logic               prev_l;
        step();
        out_q.delete(); last_q.delete();
        cfg_mul = 16'sd16384; cfg_sum = 14'sd0; cfg_ena = 1'b1;
        sto_tready = 1'b0;
        idx = 0;
        have_prev = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        drive(0, 1'b0);
        for (int c = 0; c < 400 && out_q.size() < 20; c++) begin
            @(negedge clk);
            if (have_prev) begin
                tests++;
                if (sto_tvalid !== 1'b1 || sto_tdata !== prev_d || sto_tlast !== prev_l) begin
                    fails++;
                    $display("[TB] FAIL bp_stable_c%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                             c, sto_tvalid, sto_tdata, sto_tlast, prev_d, prev_l);
                end
            end
            have_prev = sto_tvalid && !sto_tready;
            prev_d    = sto_tdata;
            prev_l    = sto_tlast;
            acc       = sti_tvalid && sti_tready;
            step();
            if (acc) idx++;
            if (idx < 20) drive(idx, idx == 19);
            else begin sti_tvalid = 1'b0; sti_tlast = 1'b0; end
            sto_tready = (c > 300) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        sto_tready = 1'b1;
        sti_tvalid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        tests++;
        if (out_q.size() != 20) begin
            fails++; $display("[TB] FAIL bp_count: got %0d expected 20", out_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                tests++;
                if (out_q[i] !== 14'(i) || last_q[i] !== (i == 19)) begin
                    fails++;
                    $display("[TB] FAIL bp_seq_%0d: got d=%0d l=%b expected d=%0d l=%b", i, out_q[i], last_q[i], i, (i == 19));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        step();
        out_q.delete(); last_q.delete();
        sto_tready = 1'b0;
        drive(1, 1'b0);
        step();
        drive(2, 1'b0);
        step();
        drive(3, 1'b0);
        step();
        sti_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (sti_tready !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_tready: got %b expected 0", sti_tready); end
        step();
        rst = 1'b0;
        sto_tready = 1'b1;
        drive(42, 1'b0);
        @(negedge clk);
        tests++;
        if (sto_tvalid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid_after: got %b expected 0", sto_tvalid); end
        for (int j = 1; j <= 3; j++) begin
            step();
            sti_tvalid = 1'b0;
            @(negedge clk);
            tests++;
            if (sto_tvalid !== (j == 3)) begin fails++; $display("[TB] FAIL rstmid_lat_c%0d: got %b expected %b", j, sto_tvalid, (j == 3)); end
        end
        tests++;
        if (sto_tdata !== 14'sd42) begin fails++; $display("[TB] FAIL rstmid_data: got %0d expected 42", sto_tdata); end
        repeat (3) step();
        @(negedge clk);
        tests++;
        if (out_q.size() != 1) begin fails++; $display("[TB] FAIL rstmid_xfers: got %0d expected 1", out_q.size()); end
    endtask

    // Sequence all scenarios then report.
    initial begin
        rst        = 1'b1;
        sti_tdata  = '0;
        sti_tlast  = 1'b0;
        sti_tvalid = 1'b0;
        sto_tready = 1'b1;
        cfg_mul    = 16'sd16384;
        cfg_sum    = '0;
        cfg_ena    = 1'b1;
        cfg_clr    = 1'b0;
        test_reset();
        test_passthrough();
        test_gain_offset();
        test_saturation();
        test_mute();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gen_out_scl.md
Name: gen_out_scl

Overview:
- Stream stage directly downstream of the arbitrary signal generator (gen).
- Consumes the generator's signed sample stream; applies a per-channel gain (fixed point, 1.0 = 2^(DWM-2)) and a DC offset, then saturates to the DAC word width.
- Forwards the result on an AXI4-Stream style master toward the DAC interface.
- Provides an output-enable mute and a saturation event counter for status readback over the system bus register block.

Parameters:
DWI, 14, input sample width (signed)
DWM, 16, gain width (signed; unity = 2^(DWM-2))
DWS, 14, offset width (signed)
DWO, 14, output sample width (signed)
CNW, 16, saturation counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sti_tdata  input  DWI  input sample, signed
sti_tlast  input  1  input packet end (burst end from gen)
sti_tvalid  input  1  input valid
sti_tready  output  1  input ready
sto_tdata  output  DWO  output sample, signed
sto_tlast  output  1  output packet end
sto_tvalid  output  1  output valid
sto_tready  input  1  output ready
cfg_mul  input  DWM  gain, signed
cfg_sum  input  DWS  offset, signed
cfg_ena  input  1  output enable; 0 forces data to 0
cfg_clr  input  1  single-cycle pulse, clears sts_sat
sts_sat  output  CNW  count of clipped output transfers, saturating

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: sto_tvalid=0, sto_tdata=0, sto_tlast=0, sts_sat=0, all internal valids=0. sti_tready=0 while rst=1.
- Pipeline: 3 register stages (S1 multiply, S2 shift+add, S3 saturate).
- Global enable: ce = ~sto_tvalid | sto_tready.
- Input handshake: sti_tready = ce & ~rst. The input transfer occurs when sti_tvalid & sti_tready.
- Pipeline advance: when ce=1, every stage advances and each stage valid takes the previous stage valid; S1 valid takes the input transfer. When ce=0, all stages hold.
- Latency: 3 cycles from the input transfer to sto_tvalid with no backpressure. Throughput is 1 sample/cycle.
- AXI stability: while sto_tvalid=1 and sto_tready=0, sto_tdata and sto_tlast hold unchanged. No bubble is inserted when ready returns.
- Config capture: cfg_mul, cfg_sum and cfg_ena are sampled into S1 alongside each accepted sample. Each output therefore uses a consistent config set. A config change mid-stream takes effect on the next accepted sample.
- S1: product p = sti_tdata * cfg_mul, signed, DWI+DWM bits, exact.
- S2: q = p >>> (DWM-2). This is an arithmetic shift, i.e. floor rounding toward -inf. Then s = q + sign_extend(cfg_sum), computed at DWI+3 bits with no overflow possible.
- S3 saturation:
  - If s > 2^(DWO-1)-1, output 2^(DWO-1)-1 and set sat=1.
  - If s < -2^(DWO-1), output -2^(DWO-1) and set sat=1.
  - Otherwise output s and set sat=0.
  - If the captured cfg_ena=0, output 0 and sat=0.
- tlast: carried unchanged through all stages alongside its sample.
- sts_sat: increments by 1 on each output transfer (sto_tvalid & sto_tready) whose sample has sat=1. It holds at all ones (no wrap). If cfg_clr=1 in the same cycle, the clear wins and that transfer is not counted.
- Reset mid-operation: in-flight samples are discarded with no output transfer. The first sample accepted after reset is released is processed normally.
- Input idle: bubbles propagate as invalid stages; no spurious sto_tvalid.

Test Plan:
- Unity passthrough: cfg_mul=16384, cfg_sum=0, ena=1, ready=1; input 100, -100, 8191, -8192 on consecutive cycles -> same values on sto_tdata, first output 3 cycles after the first transfer, sts_sat=0.
- Gain/offset/rounding: cfg_mul=8192, cfg_sum=10; input -101 -> -41 (floor of -50.5 = -51, plus 10); input 101 -> 60.
- Saturation: cfg_mul=32767; input 8000 -> 8191; input -8192 -> -8192. Then cfg_mul=16384, cfg_sum=100, input 8191 -> 8191. After these three transfers sts_sat=3; a cfg_clr pulse -> sts_sat=0.
- Backpressure: stream the ramp 0..19 with sto_tready toggled randomly -> output sequence is exactly 0..19, no drops or duplicates; data and tlast stable while stalled; tlast appears on the 20th sample only.
- Mute and config change: stream 1..10 with ena=1 and cfg_mul=16384, deasserting ena right before the 6th sample is accepted -> outputs 1..5 then 0 x5, sts_sat unchanged.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight -> no output transfers from them, sto_tvalid=0 the cycle after reset; the next input 42 appears 3 cycles after its transfer.
